// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx serial transmitter.
//   piso_state_t   : FSM state encoding (IDLE, SHIFT)
//   PISO_MIN_WIDTH : smallest word width the transmitter supports
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    localparam int PISO_MIN_WIDTH = 2;

endpackage

// File: rtl/piso_bit_cnt.sv
// Modulo-WIDTH bit counter for the serial transmitter.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   i_clr   : force the count to 0 (takes priority over i_en)
//   i_en    : advance the count; wraps to 0 after WIDTH-1
//   o_cnt   : current count
//   o_last  : count is at WIDTH-1
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            // Reload rather than wrap so non-power-of-two widths stay in range.
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter. Accepts a word via valid/ready and
// shifts it out LSB first, one bit per clock, with framing strobes.
//
//   state | meaning
//   IDLE  | nothing on the line, ready for a word
//   SHIFT | a word is being serialised
//
// Ports:
//   i_clk         : clock, rising edge
//   i_rst_n       : synchronous active-low reset
//   i_load_valid  : producer offers i_load_data
//   o_load_ready  : transmitter accepts a word this cycle (combinational)
//   i_load_data   : parallel word to send
//   o_ser_out     : serial data bit
//   o_ser_valid   : o_ser_out carries a live bit
//   o_frame_start : bit 0 of a word is on the line
//   o_frame_end   : bit WIDTH-1 of a word is on the line
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_data,
    output logic             o_ser_out,
    output logic             o_ser_valid,
    output logic             o_frame_start,
    output logic             o_frame_end
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if (WIDTH < PISO_MIN_WIDTH) begin : g_width_check
            $error("piso_tx: WIDTH must be at least %0d", PISO_MIN_WIDTH);
        end
    endgenerate

    piso_state_t      r_state;
    piso_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] w_cnt;
    logic             w_last;
    logic             w_ready;
    logic             w_xfer;
    logic             w_shifting;

    assign w_shifting = (r_state == SHIFT);
    assign w_xfer     = i_load_valid && w_ready;

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_xfer),
        .i_en    (w_shifting),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready opens on the last bit too, so a waiting word follows with no gap.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (i_load_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_ready = w_last;
                if (w_last && !i_load_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shreg <= '0;
        end else if (w_xfer) begin
            r_shreg <= i_load_data;
        end else if (w_shifting) begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

    assign o_load_ready  = w_ready;
    assign o_ser_out     = w_shifting && r_shreg[0];
    assign o_ser_valid   = w_shifting;
    assign o_frame_start = w_shifting && (w_cnt == '0);
    assign o_frame_end   = w_shifting && w_last;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: a WIDTH=4 and a WIDTH=8 instance run side
// by side, each against a queue-of-bits reference model.
module tb_piso_tx;

    logic       clk;
    logic       rst_n;
    logic       lv4, lv8;
    logic [3:0] ld4;
    logic [7:0] ld8;
    logic       rdy4, so4, sv4, fs4, fe4;
    logic       rdy8, so8, sv8, fs8, fe8;

    int total = 0;
    int bad   = 0;

    // Model: per DUT, a queue of the bits still to appear on the line,
    // each packed as {bit, first, last}; plus the words awaiting completion.
    logic [2:0]  mq   [2][$];
    logic [31:0] sent [2][$];
    logic [31:0] acc  [2];
    int          idx  [2];

    piso_tx #(.WIDTH(4)) u_dut4 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_load_valid  (lv4),
        .o_load_ready  (rdy4),
        .i_load_data   (ld4),
        .o_ser_out     (so4),
        .o_ser_valid   (sv4),
        .o_frame_start (fs4),
        .o_frame_end   (fe4)
    );

    piso_tx #(.WIDTH(8)) u_dut8 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_load_valid  (lv8),
        .o_load_ready  (rdy8),
        .i_load_data   (ld8),
        .o_ser_out     (so8),
        .o_ser_valid   (sv8),
        .o_frame_start (fs8),
        .o_frame_end   (fe8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input logic rdy, input logic so,
                             input logic sv, input logic fs, input logic fe);
        logic [2:0] e;
        string      n;
        n = (k == 0) ? "w4" : "w8";
        e = (mq[k].size() > 0) ? mq[k][0] : 3'b000;
        chk({"ready_", n}, 32'(rdy), 32'(mq[k].size() <= 1));
        chk({"ser_valid_", n}, 32'(sv), 32'(mq[k].size() > 0));
        chk({"ser_out_", n}, 32'(so), 32'(e[2]));
        chk({"frame_start_", n}, 32'(fs), 32'(e[1]));
        chk({"frame_end_", n}, 32'(fe), 32'(e[0]));
        // Reassemble the word as a receiving shift register would.
        if (sv) begin
            if (fs) begin
                acc[k] = '0;
                idx[k] = 0;
            end
            if (idx[k] < 32) acc[k][idx[k]] = so;
            idx[k]++;
            if (fe) begin
                chk({"word_pending_", n}, 32'(sent[k].size()), 32'd1);
                if (sent[k].size() > 0) chk({"word_", n}, acc[k], sent[k].pop_front());
            end
        end
    endtask

    task automatic model_edge(input int k, input int w, input logic rst,
                              input logic v, input logic [31:0] d, output logic x);
        x = rst && v && (mq[k].size() <= 1);
        if (!rst) begin
            mq[k].delete();
            sent[k].delete();
        end else begin
            if (mq[k].size() > 0) void'(mq[k].pop_front());
            if (x) begin
                for (int b = 0; b < w; b++)
                    mq[k].push_back({d[b], b == 0, b == w - 1});
                sent[k].push_back(d);
            end
        end
    endtask

    // One clock: check outputs mid-cycle, drive inputs, advance the model.
    task automatic step(input logic rst, input logic v4, input logic [3:0] d4,
                        input logic v8, input logic [7:0] d8,
                        output logic x4, output logic x8);
        @(negedge clk);
        check_dut(0, rdy4, so4, sv4, fs4, fe4);
        check_dut(1, rdy8, so8, sv8, fs8, fe8);
        rst_n = rst;
        lv4   = v4;
        ld4   = d4;
        lv8   = v8;
        ld8   = d8;
        @(posedge clk);
        model_edge(0, 4, rst, v4, 32'(d4), x4);
        model_edge(1, 8, rst, v8, 32'(d8), x8);
    endtask

    task automatic idle_cycles(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 1'b0, 8'h00, a, b);
    endtask

    initial begin
        logic       x4, x8;
        logic [3:0] w4 [2];
        logic [7:0] w8 [2];
        int         i4, i8;

        rst_n = 1'b0;
        lv4 = 1'b0; ld4 = '0;
        lv8 = 1'b0; ld8 = '0;
        acc[0] = '0; acc[1] = '0;
        idx[0] = 0;  idx[1] = 0;

        // Reset held three cycles, then released with nothing offered.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF, 1'b1, 8'hFF, x4, x8);
        idle_cycles(2);

        // Single word on each instance.
        step(1'b1, 1'b1, 4'b1011, 1'b1, 8'h81, x4, x8);
        idle_cycles(10);

        // Back-to-back words with valid held high.
        w4[0] = 4'hA; w4[1] = 4'h5;
        w8[0] = 8'h81; w8[1] = 8'h3C;
        i4 = 0; i8 = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, i4 < 2, (i4 < 2) ? w4[i4] : 4'h0,
                       i8 < 2, (i8 < 2) ? w8[i8] : 8'h00, x4, x8);
            if (x4) i4++;
            if (x8) i8++;
        end
        idle_cycles(2);

        // Backpressure: 4'hF offered mid-word, then data wiggled while busy.
        step(1'b1, 1'b1, 4'h6, 1'b1, 8'h5A, x4, x8);
        step(1'b1, 1'b0, 4'h0, 1'b0, 8'h00, x4, x8);
        step(1'b1, 1'b1, 4'hF, 1'b1, 8'hFF, x4, x8);
        step(1'b1, 1'b1, 4'hF, 1'b1, 8'hFF, x4, x8);
        step(1'b1, 1'b0, 4'h9, 1'b0, 8'h12, x4, x8);
        step(1'b1, 1'b1, 4'hF, 1'b0, 8'h34, x4, x8);
        idle_cycles(12);

        // Reset mid-word (reset also drops a simultaneous offer), then a clean word.
        step(1'b1, 1'b1, 4'hC, 1'b1, 8'hC3, x4, x8);
        idle_cycles(2);
        step(1'b0, 1'b1, 4'hE, 1'b1, 8'hEE, x4, x8);
        step(1'b1, 1'b1, 4'h3, 1'b1, 8'h81, x4, x8);
        idle_cycles(10);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 59) != 0,
                 $urandom_range(0, 3) != 0, 4'($urandom),
                 $urandom_range(0, 2) != 0, 8'($urandom), x4, x8);
        end
        idle_cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
